ahb_rr_master_arbiter: RTL

//  Shares one AHB-Lite slave (32-bit word register file, 256 words) among NUM_REQ requesters.

---
 rtl/ahb_rr_master_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ahb_rr_master_arbiter.sv
// Round-robin arbiter that shares one AHB-Lite slave among NUM_REQ requesters.
// Each requester posts single-word commands on a req/gnt/done handshake.
// One transfer is in flight at a time: IDLE -> ADDR (NONSEQ) -> DATA -> IDLE.
module ahb_rr_master_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 3
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [IDX_W-1:0]      owner,
    output logic [31:0]           HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [31:0]           HWDATA,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned PTR_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;

    // Elaboration-time parameter sanity
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (IDX_W < PTR_W) begin : g_bad_idx_w
        $error("IDX_W too narrow for NUM_REQ");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // Registered state and outputs
    state_t              r_state;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [IDX_W-1:0]    r_owner;
    logic [DATA_W-1:0]   r_haddr;
    logic [1:0]          r_htrans;
    logic                r_hwrite;
    logic [DATA_W-1:0]   r_hwdata;

    // Next-state values
    state_t              w_state_nxt;
    logic [PTR_W-1:0]    w_ptr_nxt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [NUM_REQ-1:0]  w_done_nxt;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                w_err_nxt;
    logic [IDX_W-1:0]    w_owner_nxt;
    logic [DATA_W-1:0]   w_haddr_nxt;
    logic [1:0]          w_htrans_nxt;
    logic                w_hwrite_nxt;
    logic [DATA_W-1:0]   w_hwdata_nxt;

    // Arbitration
    logic                w_found;
    logic [PTR_W-1:0]    w_win;
    logic [PTR_W-1:0]    w_cand;
    logic [DATA_W-1:0]   w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];
    logic [DATA_W-1:0]   w_addr_sel;
    logic [DATA_W-1:0]   w_wdata_sel;
    logic                w_write_sel;
    logic                w_unused_addr_lsb;

    // Split the flat command buses into per-requester words
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = req_addr[DATA_W*g +: DATA_W];
        assign w_wdata_arr[g] = req_wdata[DATA_W*g +: DATA_W];
    end

    // Search for the first pending request after the last winner, wrapping around
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = PTR_W'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Command fields of the current winner
    assign w_addr_sel        = w_addr_arr[w_win];
    assign w_wdata_sel       = w_wdata_arr[w_win];
    assign w_write_sel       = req_write[w_win];
    // Byte-lane bits are dropped: every transfer is word-aligned
    assign w_unused_addr_lsb = ^w_addr_sel[1:0];

    // Next-state and next-output logic; outputs hold unless a state acts on them
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_rr_ptr;
        w_gnt_nxt    = '0;
        w_done_nxt   = '0;
        w_rdata_nxt  = r_rdata;
        w_err_nxt    = r_err;
        w_owner_nxt  = r_owner;
        w_haddr_nxt  = r_haddr;
        w_htrans_nxt = r_htrans;
        w_hwrite_nxt = r_hwrite;
        w_hwdata_nxt = r_hwdata;

        unique case (r_state)
            S_IDLE: begin
                w_htrans_nxt = HTRANS_IDLE;
                if (w_found) begin
                    w_gnt_nxt[w_win] = 1'b1;
                    w_owner_nxt      = IDX_W'(w_win);
                    w_ptr_nxt        = w_win;
                    w_haddr_nxt      = {w_addr_sel[DATA_W-1:2], 2'b00};
                    w_hwrite_nxt     = w_write_sel;
                    w_hwdata_nxt     = w_wdata_sel;
                    w_htrans_nxt     = HTRANS_NONSEQ;
                    w_state_nxt      = S_ADDR;
                end
            end
            S_ADDR: begin
                // Address phase is held until the slave accepts it
                if (HREADY) begin
                    w_htrans_nxt = HTRANS_IDLE;
                    w_state_nxt  = S_DATA;
                end
            end
            S_DATA: begin
                w_htrans_nxt = HTRANS_IDLE;
                if (HREADY) begin
                    w_done_nxt[r_rr_ptr] = 1'b1;
                    w_rdata_nxt          = r_hwrite ? '0 : HRDATA;
                    w_err_nxt            = HRESP;
                    w_state_nxt          = S_IDLE;
                end
            end
            default: begin
                w_htrans_nxt = HTRANS_IDLE;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= PTR_W'(NUM_REQ - 1);
            r_gnt    <= '0;
            r_done   <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_owner  <= '0;
            r_haddr  <= '0;
            r_htrans <= HTRANS_IDLE;
            r_hwrite <= 1'b0;
            r_hwdata <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_rdata  <= w_rdata_nxt;
            r_err    <= w_err_nxt;
            r_owner  <= w_owner_nxt;
            r_haddr  <= w_haddr_nxt;
            r_htrans <= w_htrans_nxt;
            r_hwrite <= w_hwrite_nxt;
            r_hwdata <= w_hwdata_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign owner     = r_owner;
    assign HADDR     = r_haddr;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_hwrite;
    assign HWDATA    = r_hwdata;
    // Every transfer is a single word
    assign HSIZE     = HSIZE_WORD;

endmodule
